mem_access_unit: RTL

Load/store sequencer between the EX stage and the DataMemory doubleword port. It turns a sized, optionally signed load or store (byte, half, word, doubleword) into aligned 64-bit memory cycles. Sub-doubleword stores use read-modify-write. Loads return a zero- or sign-extended result. While an access is in flight, `busy` stalls the core.

---
 rtl/mem_access_pkg.sv | 23 ++
 rtl/lane_align.sv | 38 +++
 rtl/mem_access_unit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared types for the load/store sequencer: size encodings, FSM states and size decode.
package mem_access_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StRmwRd,
        StRmwWr,
        StWr,
        StDone
    } state_e;

    // Access width in bytes (1, 2, 4 or 8).
    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/lane_align.sv
// Big-endian byte-lane extract/extend for loads and lane merge for read-modify-write stores.
module lane_align (
    input  logic [2:0]  offset,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [63:0] dword,
    input  logic [63:0] wdata,
    output logic [63:0] load_val,
    output logic [63:0] store_dword
);
    import mem_access_pkg::*;

    logic [6:0]  lane_bits;
    logic [6:0]  off_bits;
    logic [6:0]  pad_bits;
    logic [63:0] top_aligned;
    logic [63:0] lane_mask;
    logic [63:0] ins_data;

    always_comb begin
        lane_bits = {size_bytes(size), 3'b000};
        off_bits  = {1'b0, offset, 3'b000};
        pad_bits  = 7'd64 - lane_bits;

        // Byte o is the most significant lane; shift it to the top, then back down with extension.
        top_aligned = dword << off_bits;
        if (sext) begin
            load_val = $signed(top_aligned) >>> pad_bits;
        end else begin
            load_val = top_aligned >> pad_bits;
        end

        lane_mask   = (64'hFFFF_FFFF_FFFF_FFFF << pad_bits) >> off_bits;
        ins_data    = (wdata << pad_bits) >> off_bits;
        store_dword = (dword & ~lane_mask) | (ins_data & lane_mask);
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer: turns sized EX-stage accesses into aligned doubleword memory cycles,
// using read-modify-write for sub-doubleword stores.
module mem_access_unit #(
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [63:0] rdata,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);
    import mem_access_pkg::*;

    state_e      state_q, state_d;
    logic [63:0] addr_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [63:0] wdata_q;
    logic [63:0] buf_q;
    logic [63:0] rdata_q;
    logic        fault_q, fault_d;

    logic [3:0]  req_nbytes;
    logic [3:0]  req_lsb_mask;
    logic        misaligned;
    logic        illegal;
    logic        accept;

    logic [63:0] lane_dword;
    logic [63:0] load_val;
    logic [63:0] store_dword;

    always_comb begin
        req_nbytes   = size_bytes(req_size);
        req_lsb_mask = req_nbytes - 4'd1;
        misaligned   = |(req_addr[2:0] & req_lsb_mask[2:0]);
        illegal      = (req_rd == req_wr);
        accept       = (state_q == StIdle) && req_valid;
    end

    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    fault_d = 1'b0;
                    if (illegal || (CHECK_ALIGN && misaligned)) begin
                        state_d = StDone;
                        fault_d = 1'b1;
                    end else if (req_rd) begin
                        state_d = StRd;
                    end else if (req_size == SZ_D) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRmwRd;
                    end
                end
            end
            StRd:    state_d = StDone;
            StRmwRd: state_d = StRmwWr;
            StRmwWr: state_d = StDone;
            StWr:    state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            size_q   <= SZ_B;
            signed_q <= 1'b0;
            wdata_q  <= '0;
            buf_q    <= '0;
            rdata_q  <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            if (accept) begin
                addr_q   <= req_addr;
                size_q   <= req_size;
                signed_q <= req_signed;
                wdata_q  <= req_wdata;
            end
            if (state_q == StRmwRd) begin
                buf_q <= mem_rdata;
            end
            if (state_q == StRd) begin
                rdata_q <= load_val;
            end
        end
    end

    // Load path aligns live read data; store path merges into the captured doubleword.
    assign lane_dword = (state_q == StRmwWr) ? buf_q : mem_rdata;

    lane_align u_lane_align (
        .offset      (addr_q[2:0]),
        .size        (size_q),
        .sext        (signed_q),
        .dword       (lane_dword),
        .wdata       (wdata_q),
        .load_val    (load_val),
        .store_dword (store_dword)
    );

    always_comb begin
        busy      = (state_q != StIdle) && (state_q != StDone);
        done      = (state_q == StDone);
        fault     = (state_q == StDone) && fault_q;
        mem_rd    = (state_q == StRd) || (state_q == StRmwRd);
        mem_wr    = (state_q == StRmwWr) || (state_q == StWr);
        mem_addr  = (state_q == StIdle) ? 64'd0 : {addr_q[63:3], 3'b000};
        mem_wdata = 64'd0;
        if (state_q == StRmwWr) begin
            mem_wdata = store_dword;
        end else if (state_q == StWr) begin
            mem_wdata = wdata_q;
        end
    end

    assign rdata = rdata_q;

endmodule
